// File: rtl/filter_kernel_pkg.sv
// Shared constants and types for the filter kernel multiplier scheduler.
package filter_kernel_pkg;

  localparam int unsigned MUL_DATA_W  = 64;
  localparam int unsigned MUL_LAT     = 2;
  localparam int unsigned MUL_NUM_REQ = 4;
  localparam int unsigned MUL_ID_W    = $clog2(MUL_NUM_REQ);
  localparam int unsigned MUL_PROD_W  = 2 * MUL_DATA_W;

  typedef logic [MUL_ID_W-1:0]   mul_tag_t;
  typedef logic [MUL_PROD_W-1:0] mul_prod_t;

endpackage

// File: rtl/filter_kernel_mul_64ns_64ns_128_3_1.sv
// Unsigned pipelined multiplier core: operand registers, then product register, both gated by ce.
module filter_kernel_mul_64ns_64ns_128_3_1 #(
  parameter int unsigned DIN0_W = 64,
  parameter int unsigned DIN1_W = 64,
  parameter int unsigned DOUT_W = 128
) (
  input  logic              clk,
  input  logic              ce,
  input  logic [DIN0_W-1:0] din0,
  input  logic [DIN1_W-1:0] din1,
  output logic [DOUT_W-1:0] dout
);

  logic [DIN0_W-1:0] a_reg;
  logic [DIN1_W-1:0] b_reg;
  logic [DOUT_W-1:0] buff0;

  // Datapath registers carry no reset; validity is tracked by the caller.
  always_ff @(posedge clk) begin
    if (ce) begin
      a_reg <= din0;
      b_reg <= din1;
      buff0 <= DOUT_W'(a_reg) * DOUT_W'(b_reg);
    end
  end

  assign dout = buff0;

endmodule

// File: rtl/filter_kernel_rr_arb.sv
// Round-robin arbiter: one-hot grant searched from ptr upward, ptr moves past the winner.
module filter_kernel_rr_arb
  import filter_kernel_pkg::*;
#(
  parameter int unsigned NUM_REQ = MUL_NUM_REQ,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant
);

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] ptr_nxt;

  // Pick the first request at or after ptr (wrapping) and compute the following ptr.
  always_comb begin
    int   idx;
    logic found;
    grant   = '0;
    ptr_nxt = ptr;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      idx = int'(ptr) + k;
      if (idx >= int'(NUM_REQ)) idx = idx - int'(NUM_REQ);
      if (en && !found && req[ID_W'(idx)]) begin
        found               = 1'b1;
        grant[ID_W'(idx)]   = 1'b1;
        ptr_nxt             = (idx == int'(NUM_REQ) - 1) ? '0 : ID_W'(idx + 1);
      end
    end
  end

  // Pointer state; unchanged when nothing is granted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr <= '0;
    else       ptr <= ptr_nxt;
  end

endmodule

// File: rtl/filter_kernel_mul_sched.sv
// Shares one pipelined multiplier among NUM_REQ requesters; results return tagged to the issuer.
module filter_kernel_mul_sched
  import filter_kernel_pkg::*;
#(
  parameter int unsigned NUM_REQ = MUL_NUM_REQ,
  parameter int unsigned DATA_W  = MUL_DATA_W,
  parameter int unsigned LAT     = MUL_LAT,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [2*DATA_W-1:0]       rsp_data,
  output logic                      busy,
  output logic [31:0]               op_count
);

  logic [LAT-1:0]     vld;
  logic [ID_W-1:0]    tag [LAT];
  logic               stall;
  logic               ce;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    gnt_idx;
  logic [DATA_W-1:0]  din0;
  logic [DATA_W-1:0]  din1;

  // Freeze everything while the oldest result waits on its requester.
  assign stall = vld[LAT-1] & ~rsp_ready[tag[LAT-1]];
  assign ce    = ~stall;

  filter_kernel_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (req_valid),
    .en    (ce & ~reset),
    .grant (grant)
  );

  assign req_ready = grant;

  // Encode the granted index and steer its operands into the multiplier.
  always_comb begin
    gnt_idx = '0;
    din0    = '0;
    din1    = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (grant[i]) begin
        gnt_idx = ID_W'(i);
        din0    = req_a[i*DATA_W +: DATA_W];
        din1    = req_b[i*DATA_W +: DATA_W];
      end
    end
  end

  filter_kernel_mul_64ns_64ns_128_3_1 #(
    .DIN0_W (DATA_W),
    .DIN1_W (DATA_W),
    .DOUT_W (2 * DATA_W)
  ) u_mul (
    .clk  (clk),
    .ce   (ce),
    .din0 (din0),
    .din1 (din1),
    .dout (rsp_data)
  );

  // Valid/tag shadow pipe, advancing in lockstep with the multiplier stages.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld <= '0;
      for (int s = 0; s < int'(LAT); s++) tag[s] <= '0;
    end else if (ce) begin
      vld[0] <= |grant;
      tag[0] <= gnt_idx;
      for (int s = 1; s < int'(LAT); s++) begin
        vld[s] <= vld[s-1];
        tag[s] <= tag[s-1];
      end
    end
  end

  // Route the head result to its requester.
  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      rsp_valid[i] = vld[LAT-1] && (tag[LAT-1] == ID_W'(i));
    end
  end

  assign busy = |vld;

  // Completed-response counter, wrapping naturally at 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          op_count <= '0;
    else if (|(rsp_valid & rsp_ready))  op_count <= op_count + 32'd1;
  end

endmodule

// File: tb/tb_filter_kernel_mul_sched.sv
// Bench for the shared multiplier scheduler with an in-flight-queue reference model.
module tb_filter_kernel_mul_sched;
  import filter_kernel_pkg::*;

  localparam int N = 4;
  localparam int W = 64;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*W-1:0]    req_a, req_b;
  mul_prod_t         rsp_data;
  logic              busy;
  logic [31:0]       op_count;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int        tag;
    mul_prod_t prod;
    int        age;
  } op_t;

  op_t         q[$];
  int          m_ptr;
  logic [31:0] m_cnt;

  filter_kernel_mul_sched dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] get_a(int i);
    return req_a[i*W +: W];
  endfunction

  function automatic logic [W-1:0] get_b(int i);
    return req_b[i*W +: W];
  endfunction

  function automatic mul_prod_t prod_of(int i);
    return mul_prod_t'(get_a(i)) * mul_prod_t'(get_b(i));
  endfunction

  task automatic set_op(int i, logic [W-1:0] a, logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  function automatic logic [W-1:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // Oldest op is visible once it has aged one un-stalled edge past its accept edge.
  function automatic bit presented();
    return (q.size() > 0) && (q[0].age >= 1);
  endfunction

  function automatic logic [N-1:0] onehot(int g);
    logic [N-1:0] v;
    v = '0;
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  function automatic logic [N-1:0] exp_rsp_valid();
    return presented() ? onehot(q[0].tag) : '0;
  endfunction

  function automatic bit exp_stall();
    return presented() && !rsp_ready[q[0].tag];
  endfunction

  function automatic int exp_grant();
    if (reset || exp_stall()) return -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    q.delete();
    m_ptr = 0;
    m_cnt = '0;
  endtask

  // Advance the model across one rising edge using the inputs held during the cycle.
  task automatic model_edge();
    int  g;
    op_t o;
    if (reset) begin
      model_reset();
      return;
    end
    g = exp_grant();
    if (!exp_stall()) begin
      if (presented()) begin
        void'(q.pop_front());
        m_cnt = m_cnt + 32'd1;
      end
      foreach (q[j]) q[j].age++;
      if (g >= 0) begin
        o.tag  = g;
        o.prod = prod_of(g);
        o.age  = 0;
        q.push_back(o);
        m_ptr = (g + 1) % N;
      end
    end
  endtask

  int last_grant;

  task automatic tick();
    @(posedge clk);
    last_grant = exp_grant();
    model_edge();
    #1;
  endtask

  task automatic drain();
    req_valid = '0;
    rsp_ready = '1;
    repeat (4) tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    req_valid = '0;
    rsp_ready = '1;
    req_a = '0;
    req_b = '0;
    model_reset();
    repeat (2) tick();
    req_valid = '1;
    @(negedge clk);
    tests++; if (req_ready !== '0) begin fails++; $display("FAIL reset_req_ready got=%b exp=0", req_ready); end
    tests++; if (rsp_valid !== '0) begin fails++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
    tests++; if (op_count !== 32'd0) begin fails++; $display("FAIL reset_op_count got=%0d exp=0", op_count); end
    tick();
    reset = 1'b0;
    req_valid = '0;
    tick();
  endtask

  task automatic test_single();
    req_valid = 4'b0010;
    set_op(1, 64'd3, 64'd5);
    rsp_ready = '1;
    @(negedge clk);
    tests++; if (req_ready !== 4'b0010) begin fails++; $display("FAIL single_grant got=%b exp=0010", req_ready); end
    tick();
    req_valid = '0;
    @(negedge clk);
    tests++; if (rsp_valid !== 4'b0000 || busy !== 1'b1) begin fails++; $display("FAIL single_fill got=%b/%b exp=0000/1", rsp_valid, busy); end
    tick();
    @(negedge clk);
    tests++; if (rsp_valid !== 4'b0010) begin fails++; $display("FAIL single_rsp_valid got=%b exp=0010", rsp_valid); end
    tests++; if (rsp_data !== mul_prod_t'(15)) begin fails++; $display("FAIL single_rsp_data got=%0d exp=15", rsp_data); end
    tick();
    @(negedge clk);
    tests++; if (op_count !== 32'd1) begin fails++; $display("FAIL single_op_count got=%0d exp=1", op_count); end
    tests++; if (rsp_valid !== '0 || busy !== 1'b0) begin fails++; $display("FAIL single_idle got=%b/%b exp=0000/0", rsp_valid, busy); end
    drain();
  endtask

  task automatic test_max();
    mul_prod_t exp_p;
    exp_p = 128'hFFFFFFFFFFFFFFFE0000000000000001;
    req_valid = 4'b0001;
    set_op(0, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF);
    @(negedge clk);
    tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL max_grant got=%b exp=0001", req_ready); end
    tick();
    req_valid = '0;
    tick();
    @(negedge clk);
    tests++; if (rsp_valid !== 4'b0001 || rsp_data !== exp_p) begin fails++; $display("FAIL max_product got=%h/%b exp=%h/0001", rsp_data, rsp_valid, exp_p); end
    drain();
  endtask

  task automatic test_round_robin();
    mul_prod_t pq [12];
    int s;
    int g;
    s = m_ptr;
    rsp_ready = '1;
    for (int i = 0; i < N; i++) set_op(i, rnd64(), rnd64());
    req_valid = '1;
    for (int k = 0; k < 12; k++) begin
      g = (s + k) % N;
      @(negedge clk);
      tests++; if (req_ready !== onehot(g)) begin fails++; $display("FAIL rr_grant k=%0d got=%b exp=%b", k, req_ready, onehot(g)); end
      if (k >= 2) begin
        tests++;
        if (rsp_valid !== onehot((s + k - 2) % N) || rsp_data !== pq[k-2]) begin
          fails++;
          $display("FAIL rr_rsp k=%0d got=%b/%h exp=%b/%h", k, rsp_valid, rsp_data, onehot((s + k - 2) % N), pq[k-2]);
        end
      end
      pq[k] = prod_of(g);
      tick();
      set_op(g, rnd64(), rnd64());
    end
    drain();
  endtask

  task automatic test_stall();
    mul_prod_t p0, p2, p3;
    set_op(0, rnd64(), rnd64());
    set_op(2, rnd64(), rnd64());
    set_op(3, rnd64(), rnd64());
    p0 = prod_of(0);
    p2 = prod_of(2);
    p3 = prod_of(3);
    rsp_ready = 4'b1110;
    req_valid = 4'b0001;
    @(negedge clk);
    tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL stall_issue0 got=%b exp=0001", req_ready); end
    tick();
    req_valid = 4'b0100;
    @(negedge clk);
    tests++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL stall_issue2 got=%b exp=0100", req_ready); end
    tick();
    req_valid = 4'b1000;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests++;
      if (rsp_valid !== 4'b0001 || rsp_data !== p0 || req_ready !== '0) begin
        fails++;
        $display("FAIL stall_hold c=%0d got=%b/%h/%b exp=0001/%h/0000", c, rsp_valid, rsp_data, req_ready, p0);
      end
      tick();
    end
    rsp_ready = '1;
    @(negedge clk);
    tests++; if (rsp_valid !== 4'b0001 || rsp_data !== p0 || req_ready !== 4'b1000) begin fails++; $display("FAIL stall_release got=%b/%h/%b exp=0001/%h/1000", rsp_valid, rsp_data, req_ready, p0); end
    tick();
    req_valid = '0;
    @(negedge clk);
    tests++; if (rsp_valid !== 4'b0100 || rsp_data !== p2) begin fails++; $display("FAIL stall_next got=%b/%h exp=0100/%h", rsp_valid, rsp_data, p2); end
    tick();
    @(negedge clk);
    tests++; if (rsp_valid !== 4'b1000 || rsp_data !== p3) begin fails++; $display("FAIL stall_third got=%b/%h exp=1000/%h", rsp_valid, rsp_data, p3); end
    drain();
  endtask

  task automatic test_reset_midflight();
    rsp_ready = '1;
    set_op(1, rnd64(), rnd64());
    set_op(3, rnd64(), rnd64());
    req_valid = 4'b0010;
    tick();
    req_valid = 4'b1000;
    tick();
    req_valid = '0;
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    tests++; if (busy !== 1'b0 || rsp_valid !== '0) begin fails++; $display("FAIL midreset_clear got=%b/%b exp=0/0000", busy, rsp_valid); end
    tick();
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      tests++; if (rsp_valid !== '0 || busy !== 1'b0) begin fails++; $display("FAIL midreset_stale c=%0d got=%b/%b exp=0000/0", c, rsp_valid, busy); end
      tick();
    end
    for (int i = 0; i < N; i++) set_op(i, rnd64(), rnd64());
    req_valid = '1;
    @(negedge clk);
    tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL midreset_ptr got=%b exp=0001", req_ready); end
    tests++; if (op_count !== 32'd0) begin fails++; $display("FAIL midreset_count got=%0d exp=0", op_count); end
    tick();
    drain();
  endtask

  task automatic test_idle();
    int          saved_ptr;
    logic [31:0] saved_cnt;
    saved_ptr = m_ptr;
    saved_cnt = m_cnt;
    req_valid = '0;
    for (int c = 0; c < 20; c++) begin
      rsp_ready = 4'($urandom());
      @(negedge clk);
      tests++;
      if (req_ready !== '0 || rsp_valid !== '0 || op_count !== saved_cnt) begin
        fails++;
        $display("FAIL idle c=%0d got=%b/%b/%0d exp=0000/0000/%0d", c, req_ready, rsp_valid, op_count, saved_cnt);
      end
      tick();
    end
    rsp_ready = '1;
    req_valid = '1;
    @(negedge clk);
    tests++; if (req_ready !== onehot(saved_ptr)) begin fails++; $display("FAIL idle_ptr got=%b exp=%b", req_ready, onehot(saved_ptr)); end
    tick();
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < N; i++) set_op(i, rnd64(), rnd64());
    req_valid = '0;
    for (int c = 0; c < 400; c++) begin
      rsp_ready = ($urandom_range(0, 2) == 0) ? 4'($urandom()) : '1;
      @(negedge clk);
      tests++; if (req_ready !== onehot(exp_grant())) begin fails++; $display("FAIL rnd_grant c=%0d got=%b exp=%b", c, req_ready, onehot(exp_grant())); end
      tests++; if (rsp_valid !== exp_rsp_valid()) begin fails++; $display("FAIL rnd_rsp_valid c=%0d got=%b exp=%b", c, rsp_valid, exp_rsp_valid()); end
      if (presented()) begin
        tests++; if (rsp_data !== q[0].prod) begin fails++; $display("FAIL rnd_rsp_data c=%0d got=%h exp=%h", c, rsp_data, q[0].prod); end
      end
      tests++; if (busy !== (q.size() > 0)) begin fails++; $display("FAIL rnd_busy c=%0d got=%b exp=%b", c, busy, q.size() > 0); end
      tests++; if (op_count !== m_cnt) begin fails++; $display("FAIL rnd_op_count c=%0d got=%0d exp=%0d", c, op_count, m_cnt); end
      tick();
      if (last_grant >= 0) req_valid[last_grant] = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 3) != 0) begin
          req_valid[i] = 1'b1;
          if ($urandom_range(0, 15) == 0) set_op(i, '1, '1);
          else set_op(i, rnd64(), rnd64());
        end
      end
    end
    drain();
    tests++; if (op_count !== m_cnt) begin fails++; $display("FAIL rnd_final_count got=%0d exp=%0d", op_count, m_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_max();
    test_round_robin();
    test_stall();
    test_reset_midflight();
    test_idle();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout tests=%0d", tests);
    $fatal(1, "watchdog");
  end

endmodule
